// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Row lines are active-low; the code of a key is row_index*4 + col_index.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HOLD     = 2'd2,
      RELEASE  = 2'd3
   } kp_state_e;

   localparam logic [3:0] ROW_IDLE = 4'hF;

   // Lowest low row index wins when several rows are low in one column.
   function automatic logic [3:0] key_code_f(input logic [3:0] rows, input logic [1:0] ci);
      logic [1:0] idx;
      idx = '0;
      for (int unsigned i = 4; i > 0; i--) begin
         if (!rows[i-1]) idx = 2'(i - 1);
      end
      return {idx, ci};
   endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous keypad row lines.
// Resets to all-ones so the scanner starts out seeing an idle keypad.
module keypad_sync
   import keypad_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] d,
   output logic [3:0] q
);

   logic [3:0] meta_q, meta_d;
   logic [3:0] sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= ROW_IDLE;
         sync_q <= ROW_IDLE;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/keypad_scan_controller.sv
// 4x4 matrix keypad scanner: column drive, press/release debounce,
// one-cycle key strobe and a four-code history register for the display.
module keypad_scan_controller
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV     = 16,
   parameter int unsigned DEBOUNCE_CNT = 1000
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic [3:0]  row,
   output logic [3:0]  col,
   output logic        key_valid,
   output logic [3:0]  key_code,
   output logic [15:0] data_out
);

   localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned CW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CNT - 1);

   logic [3:0] rs;

   kp_state_e   state_q, state_d;
   logic [1:0]  ci_q, ci_d;
   logic [3:0]  col_q, col_d;
   logic [DW-1:0] dwell_q, dwell_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]  rp_q, rp_d;
   logic        key_valid_q, key_valid_d;
   logic [3:0]  key_code_q, key_code_d;
   logic [15:0] data_q, data_d;

   keypad_sync u_sync (
      .clk (clk),
      .rst (rst),
      .d   (row),
      .q   (rs)
   );

   always_comb begin
      state_d     = state_q;
      ci_d        = ci_q;
      dwell_d     = dwell_q;
      cnt_d       = cnt_q;
      rp_d        = rp_q;
      key_valid_d = 1'b0;
      key_code_d  = key_code_q;
      data_d      = data_q;

      unique case (state_q)
         SCAN: begin
            // Rows are only trusted at the end of the dwell, after settle and sync delay.
            if (dwell_q == DWELL_LAST) begin
               dwell_d = '0;
               if (rs == ROW_IDLE) begin
                  ci_d = ci_q + 2'd1;
               end else begin
                  rp_d    = rs;
                  cnt_d   = '0;
                  state_d = DEBOUNCE;
               end
            end else begin
               dwell_d = dwell_q + 1'b1;
            end
         end
         DEBOUNCE: begin
            if (rs != rp_q) begin
               ci_d    = ci_q + 2'd1;
               dwell_d = '0;
               state_d = SCAN;
            end else if (cnt_q == CNT_LAST) begin
               key_valid_d = 1'b1;
               key_code_d  = key_code_f(rp_q, ci_q);
               data_d      = {data_q[11:0], key_code_d};
               state_d     = HOLD;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HOLD: begin
            if (rs == ROW_IDLE) begin
               cnt_d   = '0;
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            if (rs != ROW_IDLE) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               ci_d    = '0;
               dwell_d = '0;
               state_d = SCAN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = SCAN;
      endcase

      // Clear wins over history, but a press landing on the same edge survives as the sole entry.
      if (clr) data_d = key_valid_d ? {12'h000, key_code_d} : '0;

      col_d = ~(4'b0001 << ci_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= SCAN;
         ci_q        <= '0;
         col_q       <= 4'b1110;
         dwell_q     <= '0;
         cnt_q       <= '0;
         rp_q        <= ROW_IDLE;
         key_valid_q <= 1'b0;
         key_code_q  <= '0;
         data_q      <= '0;
      end else begin
         state_q     <= state_d;
         ci_q        <= ci_d;
         col_q       <= col_d;
         dwell_q     <= dwell_d;
         cnt_q       <= cnt_d;
         rp_q        <= rp_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
         data_q      <= data_d;
      end
   end

   assign col       = col_q;
   assign key_valid = key_valid_q;
   assign key_code  = key_code_q;
   assign data_out  = data_q;

endmodule

// File: tb/tb_keypad_scan_controller.sv
// Self-checking bench for keypad_scan_controller with a behavioural 4x4 keypad.
module tb_keypad_scan_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr;
   logic [3:0]  row;
   logic [3:0]  col;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [15:0] data_out;

   logic [15:0] pressed;
   logic        bounce_up;
   logic [15:0] exp_data;
   int          pulse_cnt = 0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   keypad_scan_controller #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .row       (row),
      .col       (col),
      .key_valid (key_valid),
      .key_code  (key_code),
      .data_out  (data_out)
   );

   // Keypad: row r is pulled low while any pressed key (r,c) has its column driven low.
   always_comb begin
      row = 4'hF;
      if (!bounce_up) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
      end
   end

   always @(negedge clk) if (key_valid === 1'b1) pulse_cnt++;

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; clr = 1'b0; pressed = '0; bounce_up = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
   endtask

   task automatic wait_pulse(input int base, input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit && !ok; i++) begin
         tick();
         if (pulse_cnt > base) ok = 1'b1;
      end
   endtask

   task automatic press_key(input int r, input int c, input int hold,
                            output bit ok, output logic [3:0] code, output logic [15:0] data);
      int base;
      base = pulse_cnt;
      pressed = '0;
      pressed[r*4+c] = 1'b1;
      wait_pulse(base, 200, ok);
      code = key_code;
      data = data_out;
      repeat (hold) tick();
      pressed = '0;
      repeat (20) tick();
   endtask

   task automatic test_reset();
      logic [3:0] one, exp_col;
      int base;
      rst = 1'b1; clr = 1'b0; pressed = '0; bounce_up = 1'b0;
      tick(); tick();
      checks++; if (col !== 4'b1110) begin errors++; $display("FAIL reset_col got %b want 1110", col); end
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", key_valid); end
      checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL reset_code got %h want 0", key_code); end
      checks++; if (data_out !== 16'h0) begin errors++; $display("FAIL reset_data got %h want 0000", data_out); end
      rst = 1'b0;
      base = pulse_cnt;
      one = 4'b0001;
      for (int k = 0; k < 20; k++) begin
         exp_col = ~(one << ((k / 4) % 4));
         checks++;
         if (col !== exp_col) begin errors++; $display("FAIL idle_rotate k=%0d got %b want %b", k, col, exp_col); end
         tick();
      end
      checks++; if (pulse_cnt != base) begin errors++; $display("FAIL idle_pulses got %0d want %0d", pulse_cnt, base); end
      checks++; if (data_out !== 16'h0) begin errors++; $display("FAIL idle_data got %h want 0000", data_out); end
   endtask

   task automatic test_single_press();
      int base, bad;
      bit ok;
      do_reset();
      base = pulse_cnt;
      pressed[2*4+1] = 1'b1;
      wait_pulse(base, 200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL single_timeout got no pulse want 1"); end
      checks++; if (key_code !== 4'h9) begin errors++; $display("FAIL single_code got %h want 9", key_code); end
      checks++; if (data_out !== 16'h0009) begin errors++; $display("FAIL single_data got %h want 0009", data_out); end
      bad = 0;
      repeat (100) begin
         tick();
         if (col !== 4'b1101) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL hold_col got %0d bad cycles want 0", bad); end
      pressed = '0;
      bad = 0;
      repeat (10) begin
         tick();
         if (col !== 4'b1101) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL release_col got %0d bad cycles want 0", bad); end
      tick();
      checks++; if (col !== 4'b1110) begin errors++; $display("FAIL release_rescan got %b want 1110", col); end
      repeat (10) tick();
      checks++; if (pulse_cnt != base + 1) begin errors++; $display("FAIL single_count got %0d want %0d", pulse_cnt - base, 1); end
   endtask

   task automatic test_sequence();
      int base;
      bit ok;
      logic [3:0] code, exp_code;
      logic [15:0] data;
      do_reset();
      exp_data = '0;
      base = pulse_cnt;
      for (int k = 1; k <= 5; k++) begin
         exp_code = 4'(k);
         press_key(k / 4, k % 4, $urandom_range(10, 60), ok, code, data);
         exp_data = {exp_data[11:0], exp_code};
         checks++; if (!ok) begin errors++; $display("FAIL seq_timeout key=%0d got no pulse", k); end
         checks++; if (code !== exp_code) begin errors++; $display("FAIL seq_code got %h want %h", code, exp_code); end
         checks++; if (data !== exp_data) begin errors++; $display("FAIL seq_data got %h want %h", data, exp_data); end
      end
      checks++; if (data_out !== 16'h2345) begin errors++; $display("FAIL seq_final got %h want 2345", data_out); end
      checks++; if (pulse_cnt != base + 5) begin errors++; $display("FAIL seq_count got %0d want 5", pulse_cnt - base); end
   endtask

   task automatic test_random();
      int r, c;
      bit ok;
      logic [3:0] code, exp_code;
      logic [15:0] data;
      for (int k = 0; k < 6; k++) begin
         r = $urandom_range(0, 3);
         c = $urandom_range(0, 3);
         exp_code = 4'(r * 4 + c);
         press_key(r, c, $urandom_range(5, 40), ok, code, data);
         exp_data = {exp_data[11:0], exp_code};
         checks++; if (!ok) begin errors++; $display("FAIL rand_timeout r=%0d c=%0d", r, c); end
         checks++; if (code !== exp_code) begin errors++; $display("FAIL rand_code got %h want %h", code, exp_code); end
         checks++; if (data !== exp_data) begin errors++; $display("FAIL rand_data got %h want %h", data, exp_data); end
      end
   endtask

   task automatic test_bounce();
      int base;
      bit ok;
      logic [3:0] code, seen;
      logic [15:0] data;
      base = pulse_cnt;
      pressed = '0;
      pressed[1*4+2] = 1'b1;
      for (int i = 0; i < 60; i++) begin
         bounce_up = ((i / 3) % 2) == 0;
         tick();
      end
      pressed = '0;
      bounce_up = 1'b0;
      repeat (20) tick();
      checks++; if (pulse_cnt != base) begin errors++; $display("FAIL bounce_pulses got %0d want 0", pulse_cnt - base); end
      seen = '0;
      repeat (16) begin
         for (int c = 0; c < 4; c++) if (col[c] === 1'b0) seen[c] = 1'b1;
         tick();
      end
      checks++; if (seen !== 4'hF) begin errors++; $display("FAIL bounce_rescan got %b want 1111", seen); end
      press_key(1, 2, 30, ok, code, data);
      exp_data = {exp_data[11:0], 4'h6};
      checks++; if (!ok) begin errors++; $display("FAIL bounce_stable_timeout got no pulse"); end
      checks++; if (code !== 4'h6) begin errors++; $display("FAIL bounce_code got %h want 6", code); end
      checks++; if (data !== exp_data) begin errors++; $display("FAIL bounce_data got %h want %h", data, exp_data); end
      checks++; if (pulse_cnt != base + 1) begin errors++; $display("FAIL bounce_count got %0d want 1", pulse_cnt - base); end
   endtask

   task automatic test_multi_key();
      int base;
      bit ok;
      base = pulse_cnt;
      pressed = '0;
      pressed[1*4+0] = 1'b1;
      pressed[3*4+0] = 1'b1;
      wait_pulse(base, 200, ok);
      exp_data = {exp_data[11:0], 4'h4};
      checks++; if (!ok) begin errors++; $display("FAIL multi_timeout got no pulse"); end
      checks++; if (key_code !== 4'h4) begin errors++; $display("FAIL multi_code got %h want 4", key_code); end
      checks++; if (data_out !== exp_data) begin errors++; $display("FAIL multi_data got %h want %h", data_out, exp_data); end
      repeat (30) tick();
      for (int b = 0; b < 4; b++) begin
         pressed = '0;
         repeat (5) tick();
         pressed[1*4+0] = 1'b1;
         pressed[3*4+0] = 1'b1;
         repeat (5) tick();
      end
      pressed = '0;
      repeat (30) tick();
      checks++; if (pulse_cnt != base + 1) begin errors++; $display("FAIL multi_count got %0d want 1", pulse_cnt - base); end
   endtask

   task automatic test_rst_mid_debounce();
      int base;
      base = pulse_cnt;
      pressed = '0;
      for (int c = 0; c < 4; c++) pressed[2*4+c] = 1'b1;
      repeat (8) tick();
      rst = 1'b1;
      tick();
      checks++; if (col !== 4'b1110) begin errors++; $display("FAIL midrst_col got %b want 1110", col); end
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", key_valid); end
      checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL midrst_code got %h want 0", key_code); end
      checks++; if (data_out !== 16'h0) begin errors++; $display("FAIL midrst_data got %h want 0000", data_out); end
      rst = 1'b0;
      pressed = '0;
      repeat (30) tick();
      checks++; if (pulse_cnt != base) begin errors++; $display("FAIL midrst_pulses got %0d want 0", pulse_cnt - base); end
      exp_data = '0;
   endtask

   task automatic test_clr();
      int base;
      bit ok;
      do_reset();
      base = pulse_cnt;
      pressed[0*4+1] = 1'b1;
      wait_pulse(base, 200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL clr_pre_timeout got no pulse"); end
      repeat (10) tick();
      pressed = '0;
      repeat (11) tick();
      checks++; if (col !== 4'b1110) begin errors++; $display("FAIL clr_rescan got %b want 1110", col); end
      pressed[3*4+3] = 1'b1;
      repeat (23) tick();
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL clr_early_valid got %b want 0", key_valid); end
      checks++; if (data_out !== 16'h0001) begin errors++; $display("FAIL clr_pre_data got %h want 0001", data_out); end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL clr_press_valid got %b want 1", key_valid); end
      checks++; if (key_code !== 4'hF) begin errors++; $display("FAIL clr_press_code got %h want f", key_code); end
      checks++; if (data_out !== 16'h000F) begin errors++; $display("FAIL clr_press_data got %h want 000f", data_out); end
      repeat (10) tick();
      pressed = '0;
      repeat (20) tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      checks++; if (data_out !== 16'h0) begin errors++; $display("FAIL clr_idle_data got %h want 0000", data_out); end
      checks++; if (key_code !== 4'hF) begin errors++; $display("FAIL clr_idle_code got %h want f", key_code); end
      checks++; if (pulse_cnt != base + 2) begin errors++; $display("FAIL clr_count got %0d want 2", pulse_cnt - base); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_data = '0;
      test_reset();
      test_single_press();
      test_sequence();
      test_random();
      test_bounce();
      test_multi_key();
      test_rst_mid_debounce();
      test_clr();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
